// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller.
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int WORD_CNT_W = 8;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Bit-source and word-consumer signals of the SIPO frame controller.
interface sipo_frame_ctrl_if #(
   parameter int WIDTH = 4
);
   import sipo_pkg::*;

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic                  start;
   logic                  abort;
   logic                  sin;
   logic                  sin_valid;
   logic                  sin_ready;
   logic [WIDTH-1:0]      pout;
   logic                  pout_valid;
   logic                  pout_ready;
   logic                  busy;
   logic [CNT_W-1:0]      bit_cnt;
   logic [WORD_CNT_W-1:0] word_cnt;

   modport master (
      output start, abort, sin, sin_valid, pout_ready,
      input  sin_ready, pout, pout_valid, busy, bit_cnt, word_cnt
   );

   modport slave (
      input  start, abort, sin, sin_valid, pout_ready,
      output sin_ready, pout, pout_valid, busy, bit_cnt, word_cnt
   );

endinterface

// File: rtl/sipo_shift_core.sv
// Serial-in shift register; clr wins over shift_en.
module sipo_shift_core #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (shift_en) begin
         q <= (MSB_FIRST != 0) ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Sequences bit collection into WIDTH-bit words and hands them to a
// one-entry output buffer, backpressuring the serial source while it is full.
module sipo_frame_ctrl #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   sipo_frame_ctrl_if.slave        bus
);
   import sipo_pkg::*;

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WIDTH-1:0]      w_q;
   logic [WIDTH-1:0]      w_word_done;
   logic [WIDTH-1:0]      w_load_word;
   logic [WIDTH-1:0]      r_pout;
   logic                  r_pout_valid;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [WORD_CNT_W-1:0] r_word_cnt;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_buf_free;
   logic                  w_drain;
   logic                  w_clr;
   logic                  w_load;

   assign w_accept   = bus.sin_valid && (r_state == SHIFT);
   assign w_last     = w_accept && (r_bit_cnt == CNT_W'(WIDTH - 1));
   assign w_drain    = r_pout_valid && bus.pout_ready;
   assign w_buf_free = !r_pout_valid || bus.pout_ready;
   assign w_clr      = bus.abort || ((r_state == IDLE) && bus.start);

   // The last bit is still on sin in the completion cycle, so the word is
   // formed from the register contents plus that bit.
   assign w_word_done = (MSB_FIRST != 0) ? {w_q[WIDTH-2:0], bus.sin}
                                         : {bus.sin, w_q[WIDTH-1:1]};

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_clr),
      .shift_en (w_accept && !bus.abort),
      .sin      (bus.sin),
      .q        (w_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_word = w_word_done;
      if (bus.abort) begin
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.start) w_state_nxt = SHIFT;
            end
            SHIFT: begin
               if (w_last) begin
                  if (w_buf_free) w_load = 1'b1;
                  else            w_state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (w_drain) begin
                  w_load      = 1'b1;
                  w_load_word = w_q;
                  w_state_nxt = SHIFT;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output buffer drains independently of the collection state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pout       <= '0;
         r_pout_valid <= 1'b0;
         r_word_cnt   <= '0;
         r_bit_cnt    <= '0;
      end else begin
         if (w_load) begin
            r_pout       <= w_load_word;
            r_pout_valid <= 1'b1;
            r_word_cnt   <= r_word_cnt + 1'b1;
         end else if (w_drain) begin
            r_pout_valid <= 1'b0;
         end
         if (w_clr || w_load) begin
            r_bit_cnt <= '0;
         end else if (w_accept) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   assign bus.sin_ready  = (r_state == SHIFT);
   assign bus.busy       = (r_state != IDLE);
   assign bus.pout       = r_pout;
   assign bus.pout_valid = r_pout_valid;
   assign bus.bit_cnt    = r_bit_cnt;
   assign bus.word_cnt   = r_word_cnt;

endmodule
